// File: rtl/buzzer_arbiter.sv
// Priority arbiter and tone/envelope sequencer for the lock-panel piezo buzzer (fail > ok > key).
// Optional feature: define BUZZ_QUEUE_EN to remember lower-priority requests until the active pattern ends.
module buzzer_arbiter #(
    parameter int unsigned KEY_HALF    = 50000,
    parameter int unsigned KEY_LEN     = 10000000,
    parameter int unsigned OK_HALF     = 25000,
    parameter int unsigned OK_LEN      = 30000000,
    parameter int unsigned FAIL_HALF   = 100000,
    parameter int unsigned FAIL_LEN    = 15000000,
    parameter int unsigned FAIL_GAP_LO = 5000000,
    parameter int unsigned FAIL_GAP_HI = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_key,
    input  logic       req_ok,
    input  logic       req_fail,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_src,
    output logic       done
);
    // Handshake: each req_* is a single-cycle pulse sampled on the rising edge; there is no ready/ack,
    // acceptance is visible one cycle later on busy/active_src (or via the pending bits when queued).

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY_KEY  = 2'd1,
        PLAY_OK   = 2'd2,
        PLAY_FAIL = 2'd3
    } state_t;

    localparam logic [31:0] KEY_HALF_M1  = 32'(KEY_HALF - 1);
    localparam logic [31:0] KEY_LEN_M1   = 32'(KEY_LEN - 1);
    localparam logic [31:0] OK_HALF_M1   = 32'(OK_HALF - 1);
    localparam logic [31:0] OK_LEN_M1    = 32'(OK_LEN - 1);
    localparam logic [31:0] FAIL_HALF_M1 = 32'(FAIL_HALF - 1);
    localparam logic [31:0] FAIL_LEN_M1  = 32'(FAIL_LEN - 1);
    localparam logic [31:0] GAP_LO       = 32'(FAIL_GAP_LO);
    localparam logic [31:0] GAP_HI       = 32'(FAIL_GAP_HI);

    state_t      state_q, state_d, start_src;
    logic [31:0] len_q, len_d, half_q, half_d;
    logic [31:0] len_lim, half_lim;
    logic        tone_q, tone_d, buzzer_q, buzzer_d, busy_q, busy_d, done_q, done_d;
    logic [3:1]  req_vec;
    logic [1:0]  req_top, pend_top, cand;
    logic        start, finish;

    function automatic logic [1:0] top_of(input logic [3:1] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

`ifdef BUZZ_QUEUE_EN
    logic [3:1] pend_q, pend_d;

    function automatic logic [3:1] below_mask(input logic [1:0] s);
        case (s)
            2'd3:    return 3'b011;
            2'd2:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [3:1] src_bit(input logic [1:0] s);
        case (s)
            2'd3:    return 3'b100;
            2'd2:    return 3'b010;
            2'd1:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            half_q   <= '0;
            tone_q   <= 1'b0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BUZZ_QUEUE_EN
            pend_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            half_q   <= half_d;
            tone_q   <= tone_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef BUZZ_QUEUE_EN
            pend_q   <= pend_d;
`endif
        end
    end

    always_comb begin
        len_lim  = '0;
        half_lim = '0;
        case (state_q)
            PLAY_KEY:  begin len_lim = KEY_LEN_M1;  half_lim = KEY_HALF_M1;  end
            PLAY_OK:   begin len_lim = OK_LEN_M1;   half_lim = OK_HALF_M1;   end
            PLAY_FAIL: begin len_lim = FAIL_LEN_M1; half_lim = FAIL_HALF_M1; end
            default:   begin len_lim = '0;          half_lim = '0;           end
        endcase
    end

    // Next-state: grant, preempt, restart or natural end.
    always_comb begin
        req_vec   = {req_fail, req_ok, req_key};
        req_top   = top_of(req_vec);
`ifdef BUZZ_QUEUE_EN
        pend_top  = top_of(pend_q);
`else
        pend_top  = 2'd0;
`endif
        cand      = (req_top > pend_top) ? req_top : pend_top;
        finish    = (state_q != IDLE) && (len_q == len_lim);
        start     = 1'b0;
        start_src = IDLE;
        state_d   = state_q;
        if (state_q == IDLE) begin
            if (cand != 2'd0) begin
                start     = 1'b1;
                start_src = state_t'(cand);
            end
        end else if (req_top >= state_q) begin
            start     = 1'b1;
            start_src = state_t'(req_top);
        end else if (finish) begin
            state_d = IDLE;
        end
        if (start) state_d = start_src;
`ifdef BUZZ_QUEUE_EN
        // Requests below whichever pattern plays next cycle are remembered; a granted source drops its bit.
        pend_d = pend_q | (req_vec & below_mask(start ? start_src : state_q));
        if (start) pend_d = pend_d & ~src_bit(start_src);
`endif
    end

    // Outputs: counters, tone phase and the fail envelope, all precomputed for the registers.
    always_comb begin
        len_d    = len_q;
        half_d   = half_q;
        tone_d   = tone_q;
        buzzer_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != IDLE);
        if (start) begin
            len_d    = '0;
            half_d   = '0;
            tone_d   = 1'b1;
            buzzer_d = 1'b1;
            done_d   = finish;
        end else if (state_d == IDLE) begin
            len_d  = '0;
            half_d = '0;
            tone_d = 1'b0;
            done_d = finish;
        end else begin
            len_d = len_q + 32'd1;
            if (half_q == half_lim) begin
                half_d = '0;
                tone_d = ~tone_q;
            end else begin
                half_d = half_q + 32'd1;
            end
            buzzer_d = tone_d & ~((state_q == PLAY_FAIL) && (len_d >= GAP_LO) && (len_d < GAP_HI));
        end
    end

    assign buzzer     = buzzer_q;
    assign busy       = busy_q;
    assign active_src = state_q;
    assign done       = done_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter: pattern-position model checked every cycle plus literal pattern expectations.
module tb_buzzer_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_key, req_ok, req_fail;
  logic       buzzer, busy, done;
  logic [1:0] active_src;

  int n_checks = 0;
  int n_errors = 0;

  buzzer_arbiter #(
    .KEY_HALF(4), .KEY_LEN(40), .OK_HALF(2), .OK_LEN(60),
    .FAIL_HALF(8), .FAIL_LEN(48), .FAIL_GAP_LO(16), .FAIL_GAP_HI(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_key(req_key), .req_ok(req_ok), .req_fail(req_fail),
    .buzzer(buzzer), .busy(busy), .active_src(active_src), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: which source plays and how far into its pattern ----------------
  int       m_src = 0;
  int       m_pos = 0;
  bit       m_done = 0;
  bit [3:1] m_pend = '0;
  bit       model_ok = 0;

  function automatic int plen(input int s);
    return (s == 1) ? 40 : (s == 2) ? 60 : 48;
  endfunction

  function automatic int phalf(input int s);
    return (s == 1) ? 4 : (s == 2) ? 2 : 8;
  endfunction

  function automatic int highest(input bit [3:1] v);
    for (int i = 3; i >= 1; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit tone_at(input int s, input int p);
    if (s == 0) return 1'b0;
    if (s == 3 && p >= 16 && p < 32) return 1'b0;
    return ((p / phalf(s)) % 2) == 0;
  endfunction

  task automatic remember_lower(input bit [3:1] rq, input int s);
`ifdef BUZZ_QUEUE_EN
    for (int i = 1; i < s; i++) if (rq[i]) m_pend[i] = 1'b1;
`endif
  endtask

  task automatic begin_pattern(input int s, input bit [3:1] rq);
    m_src = s;
    m_pos = 0;
    remember_lower(rq, s);
    m_pend[s] = 1'b0;
  endtask

  task automatic model_step(input bit [3:1] rq);
    int top, cand;
    bit fin;
    top = highest(rq);
    fin = (m_src != 0) && (m_pos == plen(m_src) - 1);
    m_done = 0;
    if (m_src == 0) begin
      cand = top;
`ifdef BUZZ_QUEUE_EN
      if (highest(m_pend) > cand) cand = highest(m_pend);
`endif
      if (cand != 0) begin_pattern(cand, rq);
    end else if (top >= m_src) begin
      m_done = fin;
      begin_pattern(top, rq);
    end else begin
      remember_lower(rq, m_src);
      if (fin) begin
        m_done = 1;
        m_src  = 0;
        m_pos  = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_src = 0; m_pos = 0; m_done = 0; m_pend = '0;
    end else begin
      model_step({req_fail, req_ok, req_key});
    end
    model_ok = 1;
  end

  // Scoreboard compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_buzzer", int'(buzzer), int'(tone_at(m_src, m_pos)));
      chk("model_busy", int'(busy), int'(m_src != 0));
      chk("model_active_src", int'(active_src), m_src);
      chk("model_done", int'(done), int'(m_done));
    end
  end

  // ---------------- driver and observation helpers ----------------
  int bz[0:255], sa[0:255], dn[0:255];
  int o_busy, o_high, o_done;
  int o_src[0:3];

  task automatic pulse(input bit k, input bit o, input bit f);
    req_key = k; req_ok = o; req_fail = f;
    @(negedge clk);
    req_key = 0; req_ok = 0; req_fail = 0;
  endtask

  task automatic observe(input int n);
    o_busy = 0; o_high = 0; o_done = 0;
    for (int s = 0; s < 4; s++) o_src[s] = 0;
    for (int i = 0; i < n; i++) begin
      bz[i] = int'(buzzer); sa[i] = int'(active_src); dn[i] = int'(done);
      o_busy += int'(busy); o_high += int'(buzzer); o_done += int'(done);
      o_src[active_src]++;
      @(negedge clk);
    end
  endtask

  task automatic key_click(input string tag);
    pulse(1, 0, 0);
    observe(50);
    chk({tag, "_busy_cycles"}, o_busy, 40);
    chk({tag, "_high_cycles"}, o_high, 20);
    chk({tag, "_done_count"}, o_done, 1);
    chk({tag, "_src1_cycles"}, o_src[1], 40);
    chk({tag, "_bz0"}, bz[0], 1);
    chk({tag, "_bz3"}, bz[3], 1);
    chk({tag, "_bz4"}, bz[4], 0);
    chk({tag, "_bz8"}, bz[8], 1);
    chk({tag, "_done_at40"}, dn[40], 1);
    chk({tag, "_bz_after"}, bz[40], 0);
  endtask

  initial begin
    rst_n = 0; req_key = 0; req_ok = 0; req_fail = 0;
    repeat (3) @(negedge clk);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_active_src", int'(active_src), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1;
    @(negedge clk);

    key_click("key");

    // Fail envelope: gap 16..31 silent, tone resumes high at 32.
    pulse(0, 0, 1);
    observe(60);
    chk("fail_busy_cycles", o_busy, 48);
    chk("fail_high_cycles", o_high, 16);
    chk("fail_bz0", bz[0], 1);
    chk("fail_bz8", bz[8], 0);
    chk("fail_bz16_gap", bz[16], 0);
    chk("fail_bz23_gap", bz[23], 0);
    chk("fail_bz32_resume", bz[32], 1);
    chk("fail_bz40", bz[40], 0);
    chk("fail_done_at48", dn[48], 1);
    chk("fail_done_count", o_done, 1);

    // Preemption: ok arrives 10 cycles into the key click.
    pulse(1, 0, 0);
    observe(10);
    chk("pre_key_done", o_done, 0);
    pulse(0, 1, 0);
    observe(70);
    chk("pre_ok_src0", sa[0], 2);
    chk("pre_ok_bz0", bz[0], 1);
    chk("pre_ok_busy", o_busy, 60);
    chk("pre_ok_high", o_high, 30);
    chk("pre_ok_done_count", o_done, 1);
    chk("pre_ok_done_at60", dn[60], 1);

    // Lower priority while busy: key at ok cycle 5.
    pulse(0, 1, 0);
    observe(5);
    pulse(1, 0, 0);
    observe(120);
    chk("low_done_at54", dn[54], 1);
    chk("low_idle_at54", sa[54], 0);
`ifdef BUZZ_QUEUE_EN
    chk("low_key_start55", sa[55], 1);
    chk("low_key_cycles", o_src[1], 40);
    chk("low_busy", o_busy, 94);
    chk("low_done_count", o_done, 2);
`else
    chk("low_key_start55", sa[55], 0);
    chk("low_key_cycles", o_src[1], 0);
    chk("low_busy", o_busy, 54);
    chk("low_done_count", o_done, 1);
`endif

    // Simultaneous requests.
    pulse(1, 1, 1);
    observe(200);
    chk("sim_src0", sa[0], 3);
    chk("sim_fail_cycles", o_src[3], 48);
`ifdef BUZZ_QUEUE_EN
    chk("sim_ok_start49", sa[49], 2);
    chk("sim_key_start110", sa[110], 1);
    chk("sim_ok_cycles", o_src[2], 60);
    chk("sim_key_cycles", o_src[1], 40);
    chk("sim_done_count", o_done, 3);
`else
    chk("sim_ok_start49", sa[49], 0);
    chk("sim_ok_cycles", o_src[2], 0);
    chk("sim_key_cycles", o_src[1], 0);
    chk("sim_done_count", o_done, 1);
`endif

    // Reset mid-pattern, with a key request possibly pending.
    pulse(0, 1, 0);
    observe(5);
    pulse(1, 0, 0);
    observe(14);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_buzzer", int'(buzzer), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_active_src", int'(active_src), 0);
    rst_n = 1;
    observe(4);
    chk("rst_no_pending_start", o_busy, 0);
    key_click("key_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Priority arbiter and tone-pattern sequencer for the single lock-panel piezo buzzer. Keypad-click, unlock-success and wrong-code requesters each pulse a request; the block grants the buzzer to one requester at a time, preempts lower-priority patterns and generates the square-wave tone and on/off envelope for the granted pattern. It sits between the keypad/lock controller and the `buzzer` pin.

## Interface
Parameters (all counts in `clk` cycles, each ≥2):
- `KEY_HALF`, 50000: key-click tone half-period.
- `KEY_LEN`, 10000000: key-click pattern length.
- `OK_HALF`, 25000: success tone half-period.
- `OK_LEN`, 30000000: success pattern length.
- `FAIL_HALF`, 100000: fail tone half-period.
- `FAIL_LEN`, 15000000: fail pattern length.
- `FAIL_GAP_LO`, 5000000: fail silent window start; must be < `FAIL_GAP_HI`.
- `FAIL_GAP_HI`, 10000000: fail silent window end; must be < `FAIL_LEN`.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_key` in 1: key-click request, 1-cycle pulse.
- `req_ok` in 1: success request, 1-cycle pulse.
- `req_fail` in 1: fail request, 1-cycle pulse.
- `buzzer` out 1: registered tone output.
- `busy` out 1: a pattern is playing.
- `active_src` out 2: 0 none, 1 key, 2 ok, 3 fail.
- `done` out 1: 1-cycle pulse when a pattern completes naturally; never on preemption.

## Operation
- States: IDLE, PLAY_KEY, PLAY_OK, PLAY_FAIL. Priority: fail > ok > key.
- Counters: 32-bit `len_cnt` (cycles since pattern start) and 32-bit `half_cnt` (cycles since last toggle).
- Start of pattern X: state PLAY_X, `len_cnt`=0, `half_cnt`=0, `buzzer`=1, `busy`=1, `active_src`=X.
- While playing, `buzzer` toggles when `half_cnt` reaches X_HALF−1, and `half_cnt` clears. High and low phases are each exactly X_HALF cycles.
- PLAY_FAIL: `buzzer` is forced 0 while `FAIL_GAP_LO` ≤ `len_cnt` < `FAIL_GAP_HI`. The toggle phase keeps running underneath, so the tone resumes in phase.
- End: when `len_cnt` reaches X_LEN−1, the next cycle shows IDLE, `buzzer`=0, `busy`=0, `active_src`=0 and `done`=1.
- New request while busy:
  - Higher priority than the active pattern: preempt and start the new pattern the next cycle. No `done`.
  - Same priority: restart the same pattern from `len_cnt`=0.
  - Lower priority: handled per Configuration.
- Simultaneous requests: the highest priority is granted. The others are treated as lower-priority requests.
- Reset: all state, counters and pending bits clear. Mid-pattern reset silences `buzzer` on the next edge.

## Timing
- Reset values: `buzzer`=0, `busy`=0, `active_src`=0, `done`=0.
- Request pulse at edge N: `buzzer`=1 and `busy`=1 visible after edge N+1. Latency is 1 cycle.
- Pattern occupies exactly X_LEN cycles of `busy`=1.
- Back-to-back patterns (pending or new request in the `done` cycle): the next pattern starts the cycle after `done`. One IDLE cycle lies between patterns.
- A request arriving in the same cycle as natural completion is treated as a request while busy; `done` still pulses.
- All outputs are registered; no combinational path from request inputs to outputs.

## Configuration
- `BUZZ_QUEUE_EN` defined:
  - Lower-priority requests set a per-source pending bit. Depth is 1; repeats coalesce.
  - On natural completion, the highest pending source starts after the `done` cycle.
  - A preempted pattern is not resumed, and its source is not re-pended.
  - Pending bits clear when their pattern starts, or on reset.
- `BUZZ_QUEUE_EN` undefined: lower-priority requests while busy are dropped; no pending state exists.

## Test plan
All scenarios use KEY_HALF=4, KEY_LEN=40, OK_HALF=2, OK_LEN=60, FAIL_HALF=8, FAIL_LEN=48, FAIL_GAP_LO=16, FAIL_GAP_HI=32.
- Key click: `req_key` pulse -> `buzzer` high 4 / low 4 for 40 cycles, `active_src`=1, then `done` 1 cycle, `buzzer`=0.
- Fail envelope: `req_fail` -> toggle every 8 cycles; `buzzer`=0 for `len_cnt` 16..31; tone resumes at 32 in phase; `done` after 48 cycles.
- Preemption: `req_key`, then `req_ok` 10 cycles later -> `active_src` 1→2 next cycle, `buzzer`=1, no `done` for key; ok plays the full 60 cycles.
- Lower priority while busy: `req_ok`, then `req_key` at cycle 5:
  - with `BUZZ_QUEUE_EN` -> ok `done`, then key starts the following cycle and plays 40 cycles;
  - without -> idle after ok `done`.
- Simultaneous: `req_key`, `req_ok` and `req_fail` in one cycle -> `active_src`=3.
  - With queue: ok, then key follow in order.
  - Without: idle after fail.
- Reset mid-pattern: `rst_n`=0 at cycle 20 of ok -> next edge: `buzzer`=0, `busy`=0, pending cleared; `req_key` after release behaves as the key click scenario.
